// File: rtl/stream_arbiter.sv
// Round-robin arbiter merging NUM_IN ready/valid streams into one registered output.
// Optionally keeps multi-beat packets contiguous by locking the grant until the last beat.
module stream_arbiter #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 4,
  parameter int LOCK   = 1,
  parameter int SRC_W  = $clog2(NUM_IN)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_IN-1:0]             IN_valid,
  input  logic [NUM_IN-1:0][WIDTH-1:0]  IN_data,
  input  logic [NUM_IN-1:0]             IN_last,
  output logic [NUM_IN-1:0]             OUT_ready,
  output logic                          OUT_valid,
  output logic [WIDTH-1:0]              OUT_data,
  output logic                          OUT_last,
  output logic [SRC_W-1:0]              OUT_src,
  input  logic                          IN_ready
);

  typedef enum logic {
    ARB_FREE,
    ARB_LOCKED
  } arb_state_e;

  localparam logic [SRC_W:0] NUM_IN_W = (SRC_W+1)'(NUM_IN);

  arb_state_e       state_q, state_d;
  logic [SRC_W-1:0] prio_q, prio_d;
  logic [SRC_W-1:0] lock_src_q, lock_src_d;

  logic             valid_q;
  logic [WIDTH-1:0] data_q;
  logic             last_q;
  logic [SRC_W-1:0] src_q;

  logic             out_rdy;
  logic             has_grant;
  logic             xfer;
  logic [SRC_W-1:0] grant;
  logic [SRC_W:0]   scan_idx;
  logic [SRC_W:0]   grant_inc;
  logic [SRC_W-1:0] next_prio;

  // Scan indices are formed one bit wider so prio+i can wrap without aliasing.
  always_comb begin
    has_grant = 1'b0;
    grant     = '0;
    scan_idx  = '0;
    if (state_q == ARB_LOCKED) begin
      grant     = lock_src_q;
      has_grant = IN_valid[lock_src_q];
    end else begin
      for (int unsigned i = 0; i < NUM_IN; i++) begin
        scan_idx = {1'b0, prio_q} + (SRC_W+1)'(i);
        if (scan_idx >= NUM_IN_W) scan_idx = scan_idx - NUM_IN_W;
        if (!has_grant && IN_valid[scan_idx[SRC_W-1:0]]) begin
          has_grant = 1'b1;
          grant     = scan_idx[SRC_W-1:0];
        end
      end
    end
  end

  always_comb begin
    out_rdy    = !valid_q || IN_ready;
    xfer       = out_rdy && has_grant;
    OUT_ready  = '0;
    if (xfer) OUT_ready[grant] = 1'b1;

    grant_inc  = {1'b0, grant} + (SRC_W+1)'(1);
    next_prio  = (grant_inc == NUM_IN_W) ? '0 : grant_inc[SRC_W-1:0];

    state_d    = state_q;
    prio_d     = prio_q;
    lock_src_d = lock_src_q;
    if (xfer) begin
      if ((LOCK != 0) && !IN_last[grant]) begin
        state_d    = ARB_LOCKED;
        lock_src_d = grant;
      end else begin
        state_d    = ARB_FREE;
        prio_d     = next_prio;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ARB_FREE;
      prio_q     <= '0;
      lock_src_q <= '0;
      valid_q    <= 1'b0;
      data_q     <= '0;
      last_q     <= 1'b0;
      src_q      <= '0;
    end else begin
      state_q    <= state_d;
      prio_q     <= prio_d;
      lock_src_q <= lock_src_d;
      if (xfer) begin
        valid_q <= 1'b1;
        data_q  <= IN_data[grant];
        last_q  <= IN_last[grant];
        src_q   <= grant;
      end else if (out_rdy) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign OUT_valid = valid_q;
  assign OUT_data  = data_q;
  assign OUT_last  = last_q;
  assign OUT_src   = src_q;

endmodule

// File: tb/tb_stream_arbiter.sv
// Scoreboard bench for stream_arbiter: a 4-input locking instance and a 3-input non-locking one.
module tb_stream_arbiter;

  typedef struct packed {
    logic [1:0]  src;
    logic [31:0] data;
    logic        last;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [3:0]        a_valid;
  logic [3:0][31:0]  a_data;
  logic [3:0]        a_last;
  logic [3:0]        a_out_ready;
  logic              a_ovalid;
  logic [31:0]       a_odata;
  logic              a_olast;
  logic [1:0]        a_osrc;
  logic              a_in_ready;

  logic [2:0]        b_valid;
  logic [2:0][31:0]  b_data;
  logic [2:0]        b_last;
  logic [2:0]        b_out_ready;
  logic              b_ovalid;
  logic [31:0]       b_odata;
  logic              b_olast;
  logic [1:0]        b_osrc;
  logic              b_in_ready;

  beat_t qa[$];
  beat_t qb[$];
  int n_cmp = 0;
  int n_err = 0;

  stream_arbiter #(.WIDTH(32), .NUM_IN(4), .LOCK(1)) dut_a (
    .clk(clk), .rst(rst),
    .IN_valid(a_valid), .IN_data(a_data), .IN_last(a_last),
    .OUT_ready(a_out_ready), .OUT_valid(a_ovalid), .OUT_data(a_odata),
    .OUT_last(a_olast), .OUT_src(a_osrc), .IN_ready(a_in_ready)
  );

  stream_arbiter #(.WIDTH(32), .NUM_IN(3), .LOCK(0)) dut_b (
    .clk(clk), .rst(rst),
    .IN_valid(b_valid), .IN_data(b_data), .IN_last(b_last),
    .OUT_ready(b_out_ready), .OUT_valid(b_ovalid), .OUT_data(b_odata),
    .OUT_last(b_olast), .OUT_src(b_osrc), .IN_ready(b_in_ready)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic beat_t mk(input int src, input logic [31:0] data, input logic last);
    beat_t b;
    b.src  = 2'(src);
    b.data = data;
    b.last = last;
    return b;
  endfunction

  function automatic logic [31:0] dv(input int s);
    return 32'hA000_0000 + 32'(s);
  endfunction

  // Monitors: pop an expected beat whenever the downstream accepts one.
  always @(negedge clk) begin : mon_a
    beat_t got;
    if (!rst && a_ovalid && a_in_ready) begin
      got = {a_osrc, a_odata, a_olast};
      if (qa.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL a_beat_unexpected: actual=%0h required=none", got);
      end else begin
        chk("a_beat", got, qa.pop_front());
      end
    end
  end

  always @(negedge clk) begin : mon_b
    beat_t got;
    if (!rst && b_ovalid && b_in_ready) begin
      got = {b_osrc, b_odata, b_olast};
      if (qb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL b_beat_unexpected: actual=%0h required=none", got);
      end else begin
        chk("b_beat", got, qb.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic drain();
    a_valid = '0;
    b_valid = '0;
    repeat (3) tick();
    chk("a_queue_empty", 64'(qa.size()), 0);
    chk("b_queue_empty", 64'(qb.size()), 0);
  endtask

  initial begin
    a_valid = '0; a_data = '0; a_last = '0; a_in_ready = 1'b1;
    b_valid = '0; b_data = '0; b_last = '0; b_in_ready = 1'b1;
    rst = 1'b1;
    tick();
    do_reset();

    // Reset state
    @(negedge clk);
    chk("rst_valid", a_ovalid, 0);
    chk("rst_data", a_odata, 0);
    chk("rst_last", a_olast, 0);
    chk("rst_src", a_osrc, 0);
    chk("rst_ready", a_out_ready, 0);
    chk("rst_b_valid", b_ovalid, 0);
    tick();

    // 1: single-beat round robin, no bubbles
    do_reset();
    a_valid = 4'hF;
    a_last  = 4'hF;
    for (int s = 0; s < 4; s++) a_data[s] = dv(s);
    for (int k = 0; k < 6; k++) begin
      qa.push_back(mk(k % 4, dv(k % 4), 1'b1));
      @(negedge clk);
      chk("t1_ready", a_out_ready, 64'(4'b0001 << (k % 4)));
      if (k > 0) chk("t1_no_bubble", a_ovalid, 1);
      tick();
    end
    drain();

    // 2: packet lock on source 2 after a single beat from source 1 moves prio to 2
    do_reset();
    a_valid   = 4'b0010;
    a_last    = 4'b0010;
    a_data[1] = dv(1);
    a_data[0] = dv(0);
    qa.push_back(mk(1, dv(1), 1'b1));
    @(negedge clk);
    chk("t2_pre_ready", a_out_ready, 4'b0010);
    tick();
    a_valid = 4'b0111;
    for (int k = 0; k < 3; k++) begin
      a_data[2] = 32'hC0DE_0000 + 32'(k);
      a_last    = (k == 2) ? 4'b0111 : 4'b0011;
      qa.push_back(mk(2, 32'hC0DE_0000 + 32'(k), k == 2));
      @(negedge clk);
      chk("t2_lock_ready", a_out_ready, 4'b0100);
      tick();
    end
    a_valid = 4'b0011;
    qa.push_back(mk(0, dv(0), 1'b1));
    @(negedge clk);
    chk("t2_after_ready", a_out_ready, 4'b0001);
    tick();
    drain();

    // 3: backpressure holds the output register for 5 cycles
    do_reset();
    a_valid   = 4'b0001;
    a_last    = 4'b0001;
    a_data[0] = 32'h1234;
    qa.push_back(mk(0, 32'h1234, 1'b1));
    qa.push_back(mk(0, 32'h5678, 1'b1));
    tick();
    a_in_ready = 1'b0;
    a_data[0]  = 32'h5678;
    repeat (5) begin
      @(negedge clk);
      chk("t3_hold_valid", a_ovalid, 1);
      chk("t3_hold_data", a_odata, 32'h1234);
      chk("t3_hold_src", a_osrc, 0);
      chk("t3_hold_last", a_olast, 1);
      chk("t3_hold_ready", a_out_ready, 0);
      tick();
    end
    a_in_ready = 1'b1;
    @(negedge clk);
    chk("t3_release_ready", a_out_ready, 4'b0001);
    tick();
    drain();

    // 4: locked source 1 goes idle for 2 cycles while source 0 waits
    do_reset();
    a_valid   = 4'b0010;
    a_last    = 4'b0000;
    a_data[1] = 32'h4000_0000;
    a_data[0] = dv(0);
    qa.push_back(mk(1, 32'h4000_0000, 1'b0));
    tick();
    a_valid = 4'b0001;
    a_last  = 4'b0001;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("t4_stall_ready", a_out_ready, 0);
      if (k == 1) chk("t4_bubble", a_ovalid, 0);
      tick();
    end
    a_valid   = 4'b0011;
    a_last    = 4'b0011;
    a_data[1] = 32'h4000_0001;
    qa.push_back(mk(1, 32'h4000_0001, 1'b1));
    @(negedge clk);
    chk("t4_resume_ready", a_out_ready, 4'b0010);
    tick();
    a_valid = 4'b0001;
    qa.push_back(mk(0, dv(0), 1'b1));
    @(negedge clk);
    chk("t4_next_ready", a_out_ready, 4'b0001);
    tick();
    drain();

    // 5: reset in the middle of a locked packet from source 3
    do_reset();
    a_valid   = 4'b1000;
    a_last    = 4'b0001;
    a_data[3] = 32'h3000_0000;
    a_data[0] = dv(0);
    qa.push_back(mk(3, 32'h3000_0000, 1'b0));
    tick();
    a_valid   = 4'b1001;
    a_data[3] = 32'h3000_0001;
    @(negedge clk);
    chk("t5_locked_ready", a_out_ready, 4'b1000);
    tick();
    rst = 1'b1;
    a_data[3] = 32'h3000_0002;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("t5_valid_after_rst", a_ovalid, 0);
    chk("t5_first_grant", a_out_ready, 4'b0001);
    qa.push_back(mk(0, dv(0), 1'b1));
    tick();
    drain();

    // 6: NUM_IN=3, LOCK=0 wraps 0,1,2 and never locks on non-last beats
    do_reset();
    b_valid = 3'b111;
    b_last  = 3'b000;
    for (int s = 0; s < 3; s++) b_data[s] = dv(s);
    for (int k = 0; k < 6; k++) begin
      qb.push_back(mk(k % 3, dv(k % 3), 1'b0));
      @(negedge clk);
      chk("t6_ready", b_out_ready, 64'(3'b001 << (k % 3)));
      chk("t6_prio", dut_b.prio_q, 64'(k % 3));
      tick();
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
